alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin controller that shares the single combinational 16-bit ALU (ADD/SUB/AND/OR, N/Z/P flags) between independent requesters, e.g. the execute stage and the address-generation path. It accepts one operation at a time over a valid/ready request channel, registers operands, drives the ALU for one cycle, captures result and flags, and returns them on the winning requester's valid/ready response channel. It sits beside the ALU and owns all of the ALU's input ports.

## Interface
- WIDTH, 16, operand/result width
- OP_W, 4, ALU opcode width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  OP_W  ALU opcode, forwarded verbatim (0000 ADD, 0001 SUB, 0010 AND, 0011 OR)
- rsp0_valid / rsp1_valid  out  1  response present
- rsp0_ready / rsp1_ready  in  1  requester consumes response
- rsp_result  out  WIDTH  result, shared by both response channels
- rsp_nzp  out  3  {N,Z,P} captured with result
- alu_a, alu_b  out  WIDTH  ALU operands (registered)
- alu_op  out  OP_W  ALU opcode (registered)
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_n, alu_z, alu_p  in  1  ALU flags
- busy  out  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbiter picks a grant among valid requesters; only the granted requester sees ready=1. The other sees ready=0. No valid → both ready=0, stay IDLE.
- Round-robin: pointer `last` holds last-served index. Both valid → grant the index != last. One valid → grant it. `last` updates only on acceptance.
- Acceptance (valid&ready in IDLE): latch a, b, op into alu_a/alu_b/alu_op, latch owner index, go EXEC.
- EXEC (exactly 1 cycle): ALU evaluates registered operands; at end of cycle capture alu_result into rsp_result and {alu_n,alu_z,alu_p} into rsp_nzp; go RESP.
- RESP: rsp<owner>_valid=1, other rsp_valid=0. Hold rsp_result/rsp_nzp stable. On rsp<owner>_ready=1 → IDLE. No new request accepted in RESP.
- Requesters must not make req_valid depend on req_ready; req_ready depends combinationally on both req_valid inputs and state.
- Opcodes are not checked; undefined opcodes return whatever the ALU produces.
- alu_a/alu_b/alu_op hold their last values in IDLE and RESP (no toggling).

## Timing
- Reset values: state=IDLE, last=1 (req0 wins first tie), req*_ready=0 during the rst cycle, rsp*_valid=0, rsp_result=0, rsp_nzp=000, alu_a=alu_b=0, alu_op=0000, busy=0.
- Accept at cycle T → EXEC at T+1 → rsp_valid first high at T+2.
- rsp_ready high at T+2 → IDLE at T+3; next acceptance earliest T+3. Peak throughput 1 op / 3 cycles.
- Backpressure: rsp_valid, rsp_result, rsp_nzp unchanged while rsp_ready=0.
- rsp_ready of the non-owner ignored.
- rst asserted in any state: in-flight op and pending response discarded, no response issued, all outputs to reset values next edge.
- Request valid dropped before acceptance: no effect; nothing latched.

## Structure
- Shared package alu_pkg: opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR), OP_W, NZP width, FSM state enum.
- One natural sub-module: rr_arb2 (2-way round-robin grant from valid vector and last pointer; purely combinational grant, pointer kept in parent).
- ALU itself instantiated outside, wired to alu_* ports.

## Test plan
- After reset, req0 ADD a=0x0005 b=0x0003, rsp0_ready=1 → req0_ready at T, rsp0_valid at T+2, rsp_result=0x0008, rsp_nzp=001, rsp1_valid stays 0.
- req1 SUB a=0x0003 b=0x0005 → rsp1_valid, rsp_result=0xFFFE, rsp_nzp=100.
- req0 AND a=0x00F0 b=0x000F → rsp_result=0x0000, rsp_nzp=010.
- After reset, req0 and req1 valid together and held → req0 served first, req1 next, then req0 (strict alternation); no simultaneous ready.
- rsp0_ready held 0 for 4 cycles in RESP → rsp0_valid, rsp_result, rsp_nzp constant, req*_ready=0, busy=1; release → IDLE next cycle.
- Assert rst during EXEC → no rsp_valid ever for that op; all outputs reset values; next request after reset processed normally with req0 tie priority.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, opcodes and FSM states.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OP_W  = 4;
  localparam int NZP_W = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels between two requesters and the ALU arbiter.
// The response data bus is shared; only the owner's rsp_valid qualifies it.
interface alu_arbiter_if
  import alu_pkg::*;
();

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OP_W-1:0]  req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OP_W-1:0]  req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [NZP_W-1:0] rsp_nzp;

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_nzp
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_nzp
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the last-served pointer
// lives in the parent so it only advances on an actual acceptance.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // On a tie favour the requester that was not served last; otherwise pass
  // the (at most one-hot) valid vector straight through.
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> evaluate (EXEC) -> respond (RESP).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_p,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last;
  logic             r_owner;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OP_W-1:0]  r_alu_op;
  logic [WIDTH-1:0] r_result;
  logic [NZP_W-1:0] r_nzp;

  logic [1:0]       w_valid;
  logic [1:0]       w_grant;
  logic [1:0]       w_req_ready;
  logic             w_accept;
  logic             w_owner_rsp_ready;

  assign w_valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .i_valid (w_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // Grants are only offered in IDLE and never during the reset cycle.
  assign w_req_ready       = (r_state == ST_IDLE && !rst) ? w_grant : 2'b00;
  assign w_accept          = |w_req_ready;
  assign w_owner_rsp_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  // Next-state logic: EXEC always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)          w_state_next = ST_EXEC;
      ST_EXEC:                        w_state_next = ST_RESP;
      ST_RESP: if (w_owner_rsp_ready) w_state_next = ST_IDLE;
      default:                        w_state_next = ST_IDLE;
    endcase
  end

  // State, pointer, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_result <= '0;
      r_nzp    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_owner <= w_grant[1];
        r_last  <= w_grant[1];
        if (w_grant[1]) begin
          r_alu_a  <= bus.req1_a;
          r_alu_b  <= bus.req1_b;
          r_alu_op <= bus.req1_op;
        end else begin
          r_alu_a  <= bus.req0_a;
          r_alu_b  <= bus.req0_b;
          r_alu_op <= bus.req0_op;
        end
      end
      // Capture at the end of EXEC; held untouched through RESP backpressure.
      if (r_state == ST_EXEC) begin
        r_result <= alu_result;
        r_nzp    <= {alu_n, alu_z, alu_p};
      end
    end
  end

  assign bus.req0_ready = w_req_ready[0];
  assign bus.req1_ready = w_req_ready[1];
  assign bus.rsp0_valid = (r_state == ST_RESP) && !r_owner;
  assign bus.rsp1_valid = (r_state == ST_RESP) &&  r_owner;
  assign bus.rsp_result = r_result;
  assign bus.rsp_nzp    = r_nzp;

  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;
  assign alu_op = r_alu_op;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level
// reference model (grant rule, fixed two-cycle latency, arithmetic result).
module tb_alu_arbiter;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OP_W-1:0]  alu_op;
  logic             alu_n, alu_z, alu_p;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_p      (alu_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External ALU stand-in.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end
  assign alu_n = alu_result[WIDTH-1];
  assign alu_z = (alu_result == '0);
  assign alu_p = !alu_result[WIDTH-1] && (alu_result != '0);

  // Reference model state: one outstanding transaction at most.
  bit               m_busy  = 1'b0;
  int               m_age   = 0;     // cycles since acceptance
  bit               m_owner = 1'b0;
  bit               m_last  = 1'b1;
  logic [WIDTH-1:0] m_a, m_b, m_res;
  logic [OP_W-1:0]  m_op;
  logic [2:0]       m_nzp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [OP_W-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    int unsigned r;
    case (op)
      4'd0:    r = (int'(a) + int'(b)) % 65536;
      4'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
      4'd2:    r = int'(a & b);
      4'd3:    r = int'(a | b);
      default: r = int'(a ^ b);
    endcase
    return r[WIDTH-1:0];
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input bit r, input bit v0, input bit v1,
                      input logic [OP_W-1:0] op0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic [OP_W-1:0] op1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                      input bit rr0, input bit rr1);
    bit g0, g1, ev0, ev1;
    rst = r;
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = rr0; bus.rsp1_ready = rr1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!r && !m_busy) begin
      if (v0 && v1) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    ev0 = m_busy && m_age >= 2 && !m_owner;
    ev1 = m_busy && m_age >= 2 &&  m_owner;
    check("req0_ready", 32'(bus.req0_ready), 32'(g0));
    check("req1_ready", 32'(bus.req1_ready), 32'(g1));
    check("rsp0_valid", 32'(bus.rsp0_valid), 32'(ev0));
    check("rsp1_valid", 32'(bus.rsp1_valid), 32'(ev1));
    check("busy", 32'(busy), 32'(m_busy));
    if (ev0 || ev1) begin
      check("rsp_result", 32'(bus.rsp_result), 32'(m_res));
      check("rsp_nzp", 32'(bus.rsp_nzp), 32'(m_nzp));
    end
    if (m_busy) begin
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_op", 32'(alu_op), 32'(m_op));
    end
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_age = 0; m_last = 1'b1;
    end else if (g0 || g1) begin
      m_busy = 1'b1; m_age = 1; m_owner = g1; m_last = g1;
      m_a  = g1 ? a1 : a0;
      m_b  = g1 ? b1 : b0;
      m_op = g1 ? op1 : op0;
      m_res = ref_alu(m_op, m_a, m_b);
      m_nzp = {m_res[WIDTH-1], m_res == '0, !m_res[WIDTH-1] && m_res != '0};
      $display("txn req%0d op=%0d a=%h b=%h -> exp %h nzp=%b", g1, m_op, m_a, m_b, m_res, m_nzp);
    end else if (m_busy) begin
      if (m_age >= 2 && (m_owner ? rr1 : rr0)) m_busy = 1'b0;
      else if (m_age < 2) m_age++;
    end
    @(negedge clk);
  endtask

  task automatic idle_step(input bit rr0, input bit rr1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, rr0, rr1);
  endtask

  task automatic check_reset_values();
    #1;
    check("rst_result", 32'(bus.rsp_result), 32'h0);
    check("rst_nzp", 32'(bus.rsp_nzp), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_alu_op", 32'(alu_op), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
    check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] ra, rb, rc;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();

    // Directed: ADD, SUB, AND with immediate response consumption.
    step(0, 1, 0, ALU_ADD, 16'h0005, 16'h0003, 4'd0, 16'h0, 16'h0, 1, 1);
    repeat (3) idle_step(1, 1);
    step(0, 0, 1, 4'd0, 16'h0, 16'h0, ALU_SUB, 16'h0003, 16'h0005, 1, 1);
    repeat (3) idle_step(1, 1);
    step(0, 1, 0, ALU_AND, 16'h00F0, 16'h000F, 4'd0, 16'h0, 16'h0, 1, 1);
    repeat (3) idle_step(1, 1);

    // Backpressure: response held four cycles, then released.
    step(0, 1, 0, ALU_OR, 16'h1234, 16'h8000, 4'd0, 16'h0, 16'h0, 0, 1);
    idle_step(0, 1);
    repeat (4) step(0, 1, 1, ALU_ADD, 16'h1, 16'h1, ALU_ADD, 16'h2, 16'h2, 0, 1);
    idle_step(1, 0);
    idle_step(1, 0);

    // Reset during EXEC: nothing should ever be returned for that op.
    step(0, 1, 0, ALU_ADD, 16'h7777, 16'h1111, 4'd0, 16'h0, 16'h0, 1, 1);
    step(1, 0, 0, 4'd0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 1, 1);
    check_reset_values();
    repeat (3) idle_step(1, 1);

    // Tie held after reset: req0 first, then strict alternation.
    repeat (12) step(0, 1, 1, ALU_ADD, 16'h0010, 16'h0001, ALU_SUB, 16'h0010, 16'h0001, 1, 1);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      step(rc[31:26] == 6'd0, rc[0], rc[1],
           4'(rc[3:2]), (rc[8] ? ra[15:0] : {12'h0, ra[3:0]}), rb[15:0],
           4'(rc[5:4]), ra[31:16], (rc[9] ? rb[31:16] : {12'h0, rb[19:16]}),
           rc[12:10] != 3'd0, rc[15:13] != 3'd0);
    end
    repeat (4) idle_step(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
